axis_downsizer: RTL and testbench

Converts a wide AXI-Stream with a per-word `keep` mask into a narrow one-word-per-beat stream. It sits directly downstream of the multi-word AXIS driver, consuming `s_*` beats of `WORDS_PER_BEAT` words. It emits only the kept words, lowest index first, and asserts `m_last` on the final kept word of each packet. All outputs are registered except `s_ready` in the default build.

---
 rtl/axis_pkg.sv | 39 +++
 rtl/axis_keep_scan.sv | 27 ++
 rtl/axis_downsizer.sv | 132 +++++++++++++
 tb/tb_axis_downsizer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream width converters: state encoding and mask utilities.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Mask helpers take masks zero-extended to MAX_WORDS bits so a single function serves every bus width.
package axis_pkg;

  localparam int MAX_WORDS = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } ds_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int lowest_set(input logic [MAX_WORDS-1:0] mask);
    int idx;
    idx = 0;
    for (int i = MAX_WORDS - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

  // True when bit idx is set and no higher bit is set.
  function automatic logic is_highest_set(input logic [MAX_WORDS-1:0] mask, input int idx);
    logic hi;
    hi = mask[idx[MAX_IDX_W-1:0]];
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (i > idx && mask[i]) hi = 1'b0;
    end
    return hi;
  endfunction

endpackage

// File: rtl/axis_keep_scan.sv
// Priority encoder over a word mask: lowest set index, any-set, exactly-one-set.
// Latency: combinational.
// Backpressure: none.
// Ports: mask (N bits) in; idx (lowest set bit), any, only_one out.
module axis_keep_scan
  import axis_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             only_one
);

  logic [MAX_WORDS-1:0] mask_ext;
  int                   lo;

  assign mask_ext = MAX_WORDS'(mask);
  assign lo       = lowest_set(mask_ext);
  assign idx      = IDX_W'(lo);
  assign any      = |mask;
  // The lowest set bit is also the highest exactly when a single bit remains.
  assign only_one = any && is_highest_set(mask_ext, lo);

endmodule

// File: rtl/axis_downsizer.sv
// Wide-to-narrow AXI-Stream converter: emits only kept words, lowest index first, m_last on final kept word.
// Latency: first word of a beat accepted at edge T is valid in cycle T+1; one word per cycle after that.
// Backpressure: s_ready = !full || (m_ready && last word presented); with AXIS_DOWNSIZER_REG_READY_EN it is a flop (!full), costing one bubble per beat.
// Ports: clk, rst (async, active high); s_valid/s_ready/s_data/s_keep/s_last wide slave side;
//        m_valid/m_ready/m_data/m_last narrow master side. m_* outputs are registered.
// Build option: define AXIS_DOWNSIZER_REG_READY_EN to break the m_ready -> s_ready combinational path.
module axis_downsizer
  import axis_pkg::*;
#(
  parameter int  WORD_W         = 8,
  parameter int  BUS_W          = 32,
  localparam int WORDS_PER_BEAT = ceil_div(BUS_W, WORD_W)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  input  logic [WORDS_PER_BEAT-1:0]             s_keep,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WORD_W-1:0]                     m_data,
  output logic                                  m_last
);

  localparam int IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  generate
    if ((BUS_W % WORD_W) != 0 || WORDS_PER_BEAT < 1 || WORDS_PER_BEAT > MAX_WORDS) begin : g_bad_params
      $fatal(1, "axis_downsizer: BUS_W must be a non-zero multiple of WORD_W within MAX_WORDS words");
    end
  endgenerate

  ds_state_t                            state_q, state_d;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data_q, data_d;
  logic [WORDS_PER_BEAT-1:0]             keep_q, keep_d;
  logic                                  last_q, last_d;
  logic [IDX_W-1:0]                      idx_q;
  logic [IDX_W-1:0]                      scan_idx;
  logic                                  scan_any, scan_one;
  logic [WORD_W-1:0]                     m_data_d;
  logic                                  m_last_d;
  logic                                  m_fire, s_fire;

  assign m_valid = (state_q == ST_DRAIN);
  assign m_fire  = m_valid && m_ready;
  assign s_fire  = s_valid && s_ready;

  // Scan the *next* remaining mask so the presented word and m_last can be registered.
  axis_keep_scan #(
    .N     (WORDS_PER_BEAT),
    .IDX_W (IDX_W)
  ) u_scan (
    .mask     (keep_d),
    .idx      (scan_idx),
    .any      (scan_any),
    .only_one (scan_one)
  );

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    if (m_fire) begin
      keep_d = keep_q & ~(WORDS_PER_BEAT'(1) << idx_q);
    end
    // A beat is only accepted when the buffer is empty or being emptied this edge,
    // so loading over the old contents never loses a word. keep==0 loads an empty mask,
    // which discards the beat (and its last flag) outright.
    if (s_fire) begin
      data_d = s_data;
      keep_d = s_keep;
      last_d = s_last;
    end
    state_d  = scan_any ? ST_DRAIN : ST_EMPTY;
    m_data_d = data_d[scan_idx];
    m_last_d = last_d && scan_one;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      idx_q   <= scan_idx;
      if (scan_any) begin
        m_data <= m_data_d;
        m_last <= m_last_d;
      end else begin
        m_last <= 1'b0;
      end
    end
  end

`ifdef AXIS_DOWNSIZER_REG_READY_EN
  logic s_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= (state_d == ST_EMPTY);
    end
  end

  assign s_ready = s_ready_q;
`else
  // Registered "one word left" flag keeps the m_ready -> s_ready path to a single AND/OR.
  logic one_left_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      one_left_q <= 1'b0;
    end else begin
      one_left_q <= scan_one;
    end
  end

  assign s_ready = !rst && (!m_valid || (m_ready && one_left_q));
`endif

endmodule

// File: tb/tb_axis_downsizer.sv
// Self-checking bench for axis_downsizer (WORD_W=8, BUS_W=32).
// Latency: n/a.
// Backpressure: m_ready is driven either constantly high or randomly toggling.
module tb_axis_downsizer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [3:0][7:0]  s_data = '0;
  logic [3:0]       s_keep = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [7:0]       m_data;
  logic             m_last;

  axis_downsizer #(.WORD_W(8), .BUS_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } obs_t;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_cyc = 0;
  int         exp_total = 0;
  bit         rand_mode = 1'b0;
  logic [8:0] exp_q[$];   // {last, data} in the order words must leave
  obs_t       log_q[$];   // every word actually handed off
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_mode) m_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: scoreboard model of kept words, checked on every handshake and stall.
  always @(negedge clk) begin
    logic [8:0] e;
    int hi;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_s_ready", s_ready, 0);
    end else begin
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_data, 9'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e[7:0]);
          chk("m_last", m_last, e[8]);
        end
        log_q.push_back('{d: m_data, l: m_last, c: cyc});
      end
      if (s_valid && s_ready) begin
        hi = -1;
        for (int i = 0; i < 4; i++) if (s_keep[i]) hi = i;
        for (int i = 0; i < 4; i++)
          if (s_keep[i]) exp_q.push_back({s_last && (i == hi), s_data[i]});
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit got;
    got = 1'b0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) chk("s_ready_timeout", 0, 1);
    acc_cyc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!m_valid && exp_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nlast;
    logic [31:0] rd;
    logic [3:0]  rk;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_s_ready", s_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", s_ready, 1);
    chk("idle_m_valid", m_valid, 0);

    // Full beat, m_ready high
    log_q.delete();
    send_beat(32'h04030201, 4'b1111, 1'b1);
    wait_idle();
    chk("full_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("full_latency", log_q[0].c, acc_cyc);
      for (int i = 0; i < 4; i++) begin
        chk("full_data", log_q[i].d, i + 1);
        chk("full_last", log_q[i].l, (i == 3));
        chk("full_cycle", log_q[i].c, log_q[0].c + i);
      end
    end

    // Two-beat partial packet, back to back
    log_q.delete();
    send_beat(32'h04030201, 4'b1111, 1'b0);
    send_beat(32'hEEFF0605, 4'b0011, 1'b1);
    wait_idle();
    chk("partial_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("partial_data", log_q[i].d, i + 1);
        chk("partial_last", log_q[i].l, (i == 5));
      end
`ifdef AXIS_DOWNSIZER_REG_READY_EN
      chk("beat_gap", log_q[4].c - log_q[3].c, 2);
`else
      chk("beat_gap", log_q[4].c - log_q[3].c, 1);
`endif
    end

    // Sparse keep
    log_q.delete();
    send_beat(32'h04030201, 4'b1010, 1'b1);
    wait_idle();
    chk("sparse_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("sparse_d0", log_q[0].d, 8'h02);
      chk("sparse_l0", log_q[0].l, 0);
      chk("sparse_d1", log_q[1].d, 8'h04);
      chk("sparse_l1", log_q[1].l, 1);
    end

    // Zero-keep beat between two packets
    log_q.delete();
    send_beat(32'h14131211, 4'b1111, 1'b1);
    send_beat(32'hFFFFFFFF, 4'b0000, 1'b1);
    send_beat(32'h24232221, 4'b1111, 1'b1);
    wait_idle();
    chk("zero_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      nlast = 0;
      foreach (log_q[i]) if (log_q[i].l) nlast++;
      chk("zero_nlast", nlast, 2);
      chk("zero_last_a", log_q[3].l, 1);
      chk("zero_d3", log_q[3].d, 8'h14);
      chk("zero_d4", log_q[4].d, 8'h21);
      chk("zero_d7", log_q[7].d, 8'h24);
      chk("zero_last_b", log_q[7].l, 1);
    end

    // Reset after the second of four words
    log_q.delete();
    send_beat(32'h34333231, 4'b1111, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (log_q.size() >= 2) break;
      @(posedge clk);
      #1;
    end
    chk("pre_reset_words", log_q.size(), 2);
    rst = 1'b1;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_m_last", m_last, 0);
    chk("async_m_data", m_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    send_beat(32'h00000B0A, 4'b0011, 1'b1);
    wait_idle();
    chk("post_reset_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("post_reset_d0", log_q[0].d, 8'h0A);
      chk("post_reset_l0", log_q[0].l, 0);
      chk("post_reset_d1", log_q[1].d, 8'h0B);
      chk("post_reset_l1", log_q[1].l, 1);
    end

    // Random backpressure with sparse 20% input traffic
    log_q.delete();
    exp_total = 0;
    rand_mode = 1'b1;
    for (int b = 0; b < 60; b++) begin
      while ($urandom_range(0, 99) >= 20) begin
        @(posedge clk);
        #1;
      end
      rd = $urandom;
      rk = 4'($urandom_range(0, 15));
      exp_total += $countones(rk);
      send_beat(rd, rk, ($urandom_range(0, 2) == 0));
    end
    wait_idle();
    rand_mode = 1'b0;
    m_ready = 1'b1;
    chk("rand_count", log_q.size(), exp_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
